alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: two-requester round-robin front end for a shared ALU.
// One command is in flight at a time. Codes with the MSB set run twice,
// the second pass carrying the first pass's carry-out as carry-in, to
// build a 128-bit result. A per-pass cycle budget turns a silent ALU
// into an error response instead of a hang.
module alu_issue_ctrl #(
    parameter int LEN_DATA     = 64,
    parameter int LEN_TYPE_ALU = 6,
    parameter int TIMEOUT      = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    req_valid0,
    output logic                    req_ready0,
    input  logic [LEN_TYPE_ALU-1:0] req_code0,
    input  logic [LEN_DATA-1:0]     req_a0,
    input  logic [LEN_DATA-1:0]     req_b0,
    input  logic [LEN_DATA-1:0]     req_imm0,
    input  logic                    req_cin0,

    input  logic                    req_valid1,
    output logic                    req_ready1,
    input  logic [LEN_TYPE_ALU-1:0] req_code1,
    input  logic [LEN_DATA-1:0]     req_a1,
    input  logic [LEN_DATA-1:0]     req_b1,
    input  logic [LEN_DATA-1:0]     req_imm1,
    input  logic                    req_cin1,

    output logic                    alu_en,
    output logic [LEN_TYPE_ALU-1:0] alu_code,
    output logic [LEN_DATA-1:0]     alu_a,
    output logic [LEN_DATA-1:0]     alu_b,
    output logic [LEN_DATA-1:0]     alu_imm,
    output logic                    alu_cin,
    input  logic [LEN_DATA-1:0]     alu_result,
    input  logic [LEN_DATA-1:0]     alu_ex_result,
    input  logic                    alu_cout,
    input  logic                    alu_rdy,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [LEN_DATA-1:0]     rsp_result,
    output logic [LEN_DATA-1:0]     rsp_ex_result,
    output logic                    rsp_cout,
    output logic                    rsp_err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STEP2,
        RESP
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       second_pass;
    logic       grant_any;
    logic       grant_id;
    logic       two_step;
    logic       timed_out;
    logic       handshake;

    assign two_step  = alu_code[LEN_TYPE_ALU-1];
    assign timed_out = (cnt == 4'(TIMEOUT));
    assign handshake = grant_any;
    assign alu_en    = (state == ISSUE) || (state == STEP2);
    assign rsp_valid = (state == RESP);

    // Round-robin grant: offered only in IDLE and never while reset is held.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (rst_n && state == IDLE) begin
            if (req_valid0 && req_valid1) begin
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end else if (req_valid0) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req_valid1) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
        req_ready0 = grant_any && !grant_id;
        req_ready1 = grant_any && grant_id;
    end

    // Next-state decode; alu_rdy only matters while waiting on a pass.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (handshake) next_state = ISSUE;
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (alu_rdy) begin
                    if (two_step && !second_pass) next_state = STEP2;
                    else                          next_state = RESP;
                end else if (timed_out) begin
                    next_state = RESP;
                end
            end
            STEP2: next_state = WAIT;
            RESP:  if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Command capture, pass bookkeeping, timeout counter and response payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_code      <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_imm       <= '0;
            alu_cin       <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_result    <= '0;
            rsp_ex_result <= '0;
            rsp_cout      <= 1'b0;
            rsp_err       <= 1'b0;
            cnt           <= '0;
            last_grant    <= 1'b1;
            second_pass   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        alu_code    <= grant_id ? req_code1 : req_code0;
                        alu_a       <= grant_id ? req_a1    : req_a0;
                        alu_b       <= grant_id ? req_b1    : req_b0;
                        alu_imm     <= grant_id ? req_imm1  : req_imm0;
                        alu_cin     <= grant_id ? req_cin1  : req_cin0;
                        rsp_id      <= grant_id;
                        last_grant  <= grant_id;
                        second_pass <= 1'b0;
                        rsp_err     <= 1'b0;
                    end
                end
                ISSUE, STEP2: begin
                    cnt <= '0;
                end
                WAIT: begin
                    if (alu_rdy) begin
                        if (two_step && !second_pass) begin
                            rsp_result  <= alu_result;
                            alu_cin     <= alu_cout;
                            second_pass <= 1'b1;
                        end else if (second_pass) begin
                            rsp_ex_result <= alu_result;
                            rsp_cout      <= alu_cout;
                            rsp_err       <= 1'b0;
                        end else begin
                            rsp_result    <= alu_result;
                            rsp_ex_result <= alu_ex_result;
                            rsp_cout      <= alu_cout;
                            rsp_err       <= 1'b0;
                        end
                    end else if (timed_out) begin
                        rsp_result    <= '0;
                        rsp_ex_result <= '0;
                        rsp_cout      <= 1'b0;
                        rsp_err       <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomised bench for alu_issue_ctrl. The bench plays both requesters and
// the ALU (an adder with carry), and predicts grants and responses from the
// round-robin and response rules at transaction level.
module tb_alu_issue_ctrl;

    localparam int LD = 64;
    localparam int LT = 6;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid0 = 1'b0, req_valid1 = 1'b0;
    logic          req_ready0, req_ready1;
    logic [LT-1:0] req_code0 = '0, req_code1 = '0;
    logic [LD-1:0] req_a0 = '0, req_b0 = '0, req_imm0 = '0;
    logic [LD-1:0] req_a1 = '0, req_b1 = '0, req_imm1 = '0;
    logic          req_cin0 = 1'b0, req_cin1 = 1'b0;
    logic          alu_en;
    logic [LT-1:0] alu_code;
    logic [LD-1:0] alu_a, alu_b, alu_imm;
    logic          alu_cin;
    logic [LD-1:0] alu_result = '0, alu_ex_result = '0;
    logic          alu_cout = 1'b0, alu_rdy = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id;
    logic [LD-1:0] rsp_result, rsp_ex_result;
    logic          rsp_cout, rsp_err;

    int checks = 0;
    int passed = 0;
    int en_count = 0;
    int last_grant = 1;

    logic [LT-1:0] f_code[2];
    logic [LD-1:0] f_a[2], f_b[2], f_imm[2];
    logic          f_cin[2];

    alu_issue_ctrl #(.LEN_DATA(LD), .LEN_TYPE_ALU(LT), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid0(req_valid0), .req_ready0(req_ready0), .req_code0(req_code0),
        .req_a0(req_a0), .req_b0(req_b0), .req_imm0(req_imm0), .req_cin0(req_cin0),
        .req_valid1(req_valid1), .req_ready1(req_ready1), .req_code1(req_code1),
        .req_a1(req_a1), .req_b1(req_b1), .req_imm1(req_imm1), .req_cin1(req_cin1),
        .alu_en(alu_en), .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b),
        .alu_imm(alu_imm), .alu_cin(alu_cin), .alu_result(alu_result),
        .alu_ex_result(alu_ex_result), .alu_cout(alu_cout), .alu_rdy(alu_rdy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_ex_result(rsp_ex_result),
        .rsp_cout(rsp_cout), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Issue pulses last a whole cycle, so counting on the falling edge sees each once.
    always @(negedge clk) if (alu_en) en_count++;

    task automatic checkOutput(input string tag, input logic [LD-1:0] obs, input logic [LD-1:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] mask);
        req_valid0 = mask[0]; req_code0 = f_code[0]; req_a0 = f_a[0];
        req_b0 = f_b[0]; req_imm0 = f_imm[0]; req_cin0 = f_cin[0];
        req_valid1 = mask[1]; req_code1 = f_code[1]; req_a1 = f_a[1];
        req_b1 = f_b[1]; req_imm1 = f_imm[1]; req_cin1 = f_cin[1];
    endtask

    // One full command: grant, one or two ALU passes (or a timeout), response.
    // mode 0 random operands, 1 ADD 5+7, 2 two-step with carry out of pass one.
    task automatic run_command(input logic [1:0] mask, input int mode, input int d1,
                               input int d2, input int rsp_delay);
        int g, d;
        logic two, ok, pass_cin, e_cout, e_err;
        logic [LD:0] sum;
        logic [LD-1:0] e_res, e_ex;
        for (int i = 0; i < 2; i++) begin
            if (mode == 0) begin
                f_code[i] = LT'($urandom);
                f_a[i] = {$urandom, $urandom};
                f_b[i] = {$urandom, $urandom};
                f_imm[i] = {$urandom, $urandom};
                f_cin[i] = 1'($urandom);
            end else if (mode == 1) begin
                f_code[i] = '0; f_a[i] = 64'd5; f_b[i] = 64'd7; f_imm[i] = '0; f_cin[i] = 1'b0;
            end else begin
                f_code[i] = 6'h21; f_a[i] = '1; f_b[i] = 64'd1; f_imm[i] = 64'd9; f_cin[i] = 1'b0;
            end
        end
        applyStimulus(mask);
        #1;
        if (mask == 2'b11) g = (last_grant == 0) ? 1 : 0;
        else g = mask[1] ? 1 : 0;
        checkOutput("grant_ready0", req_ready0, g == 0);
        checkOutput("grant_ready1", req_ready1, g == 1);
        step();
        last_grant = g;
        checkOutput("issue_en", alu_en, 1);
        checkOutput("issue_code", alu_code, f_code[g]);
        checkOutput("issue_a", alu_a, f_a[g]);
        checkOutput("issue_b", alu_b, f_b[g]);
        checkOutput("issue_imm", alu_imm, f_imm[g]);
        checkOutput("issue_cin", alu_cin, f_cin[g]);
        checkOutput("busy_ready", req_ready0 | req_ready1, 0);
        two = f_code[g][LT-1];
        pass_cin = f_cin[g];
        e_res = '0; e_ex = '0; e_cout = 1'b0; e_err = 1'b0;
        sum = '0;
        for (int p = 0; p < (two ? 2 : 1); p++) begin
            d = (p == 0) ? d1 : d2;
            ok = 1'b0;
            for (int k = 0; k <= TO; k++) begin
                step();
                alu_rdy = 1'b0;
                checkOutput("wait_en", alu_en, 0);
                checkOutput("wait_valid", rsp_valid, 0);
                if (k == d) begin
                    sum = {1'b0, f_a[g]} + {1'b0, f_b[g]} + (LD+1)'(pass_cin);
                    alu_result = sum[LD-1:0];
                    alu_cout = sum[LD];
                    alu_ex_result = {$urandom, $urandom};
                    alu_rdy = 1'b1;
                    ok = 1'b1;
                    if (!two) begin
                        e_res = sum[LD-1:0]; e_ex = alu_ex_result; e_cout = sum[LD];
                    end else if (p == 0) begin
                        e_res = sum[LD-1:0];
                    end else begin
                        e_ex = sum[LD-1:0]; e_cout = sum[LD];
                    end
                    step();
                    alu_rdy = 1'b0;
                    break;
                end
            end
            if (!ok) begin
                step();
                e_err = 1'b1; e_res = '0; e_ex = '0; e_cout = 1'b0;
                break;
            end
            if (two && p == 0) begin
                checkOutput("step2_en", alu_en, 1);
                checkOutput("step2_cin", alu_cin, sum[LD]);
                checkOutput("step2_a", alu_a, f_a[g]);
                checkOutput("step2_code", alu_code, f_code[g]);
                pass_cin = sum[LD];
                if (mode == 0 && $urandom_range(0, 1) == 1) begin
                    alu_result = {$urandom, $urandom};
                    alu_rdy = 1'b1;
                end
            end
        end
        checkOutput("rsp_valid", rsp_valid, 1);
        checkOutput("rsp_id", rsp_id, g);
        checkOutput("rsp_result", rsp_result, e_res);
        checkOutput("rsp_ex_result", rsp_ex_result, e_ex);
        checkOutput("rsp_cout", rsp_cout, e_cout);
        checkOutput("rsp_err", rsp_err, e_err);
        checkOutput("resp_ready", req_ready0 | req_ready1, 0);
        for (int r = 0; r < rsp_delay; r++) begin
            rsp_ready = 1'b0;
            alu_rdy = 1'($urandom);
            alu_result = {$urandom, $urandom};
            step();
            checkOutput("hold_valid", rsp_valid, 1);
            checkOutput("hold_result", rsp_result, e_res);
            checkOutput("hold_ex", rsp_ex_result, e_ex);
            checkOutput("hold_err", rsp_err, e_err);
            checkOutput("hold_ready", req_ready0 | req_ready1, 0);
        end
        alu_rdy = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("rsp_done", rsp_valid, 0);
    endtask

    initial begin
        int e0;
        for (int i = 0; i < 2; i++) begin
            f_code[i] = '0; f_a[i] = '0; f_b[i] = '0; f_imm[i] = '0; f_cin[i] = 1'b0;
        end

        // Reset values, with both requesters already asking.
        req_valid0 = 1'b1; req_valid1 = 1'b1;
        #12;
        checkOutput("rst_ready0", req_ready0, 0);
        checkOutput("rst_ready1", req_ready1, 0);
        checkOutput("rst_alu_en", alu_en, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_result", rsp_result, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // ADD 5+7 with both requesting: requester 0 first, then requester 1.
        run_command(2'b11, 1, 1, 0, 0);
        checkOutput("add64_result", rsp_result, 64'd12);
        checkOutput("add64_id", rsp_id, 0);
        run_command(2'b11, 1, 1, 0, 0);
        checkOutput("add64_next_id", rsp_id, 1);

        // Two-step command whose first pass carries out.
        e0 = en_count;
        run_command(2'b01, 2, 2, 3, 1);
        checkOutput("two_step_pulses", en_count - e0, 2);
        checkOutput("two_step_ex", rsp_ex_result, 64'd1);

        // Silent ALU on single-step, on a two-step's second pass, and long stall.
        run_command(2'b10, 1, TO + 1, 0, 0);
        run_command(2'b01, 2, 0, TO + 1, 0);
        run_command(2'b01, 1, TO, 0, 5);

        // Reset pulsed mid-WAIT, spurious alu_rdy around the release.
        f_code[0] = '0; f_a[0] = 64'd3; f_b[0] = 64'd4; f_imm[0] = '0; f_cin[0] = 1'b0;
        applyStimulus(2'b01);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_en", alu_en, 0);
        checkOutput("midrst_code", alu_code, 0);
        checkOutput("midrst_a", alu_a, 0);
        checkOutput("midrst_valid", rsp_valid, 0);
        checkOutput("midrst_ready0", req_ready0, 0);
        alu_rdy = 1'b1; alu_result = 64'hdead;
        req_valid0 = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        alu_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("midrst_no_rsp", rsp_valid, 0);
        end
        last_grant = 1;
        run_command(2'b11, 0, 2, 1, 0);

        // Continuous requests from both, then a lone requester.
        for (int i = 0; i < 8; i++) run_command(2'b11, 0, $urandom_range(0, 3), $urandom_range(0, 3), 0);
        for (int i = 0; i < 3; i++) run_command(2'b10, 0, 0, 0, 0);

        // Random mix.
        for (int i = 0; i < 30; i++) begin
            run_command(2'($urandom_range(1, 3)), 0,
                        ($urandom_range(0, 5) == 0) ? TO + 1 : $urandom_range(0, TO),
                        ($urandom_range(0, 5) == 0) ? TO + 1 : $urandom_range(0, TO),
                        $urandom_range(0, 3));
        end
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
